servo_pwm_generator: RTL and testbench
======================================

// Module: servo_pwm_generator
// PURPOSE
//  Consumes the servo pulse width (in clock cycles) from the angle-to-pulse-length stage and drives the servo PWM pin.
//  Produces a fixed 20 ms frame at 100 MHz; each frame's high time equals the pulse width latched at the frame boundary.
//  Double-buffers updates so no frame is ever truncated or stretched mid-pulse; clamps out-of-range widths.
// PARAMETERS
//  PERIOD_CYCLES  2000000  frame length in clk cycles (20 ms @ 100 MHz); must be > MAX_PULSE
//  MIN_PULSE      60000    lowest legal high time (0.6 ms)
//  MAX_PULSE      210000   highest legal high time (2.1 ms)
//  RESET_PULSE    135000   pending/active width after reset (servo centre)
//  CNT_W          21       frame counter width; 2**CNT_W >= PERIOD_CYCLES
// PORTS
//  clk                 in   1   system clock, 100 MHz
//  reset               in   1   synchronous, active-high
//  enable              in   1   1 = generate frames; 0 = stop at end of current frame
//  pulse_length        in   18  requested high time in cycles (unsigned)
//  load                in   1   1-cycle strobe: capture pulse_length into pending register
//  pwm_out             out  1   servo control output (registered)
//  frame_start         out  1   1-cycle pulse in the first cycle of each frame
//  active_pulse        out  18  high time used by the current frame
//  running             out  1   1 while a frame is in progress
// BEHAVIOUR
//  Reset (sync, priority over everything): state=IDLE, count=0, pending=active_pulse=RESET_PULSE,
//   pwm_out=0, frame_start=0, running=0.
//  Clamp on load: pending <= (pulse_length<MIN_PULSE) ? MIN_PULSE : (pulse_length>MAX_PULSE) ? MAX_PULSE : pulse_length.
//   Load accepted in any state, any cycle; last load before a frame boundary wins.
//  States:
//   IDLE: pwm_out=0, running=0, count held at 0. If enable=1 -> START next cycle.
//   RUN : count increments by 1 each cycle, 0..PERIOD_CYCLES-1.
//  Frame boundary (cycle where count==0 in RUN): active_pulse <= pending (same-cycle load bypasses:
//   load in the cycle before the boundary is visible in that frame); frame_start=1 for that one cycle.
//  Output timing (all registered, aligned with count): pwm_out=1 for cycles count=0..active_pulse-1,
//   0 for count=active_pulse..PERIOD_CYCLES-1; exactly active_pulse high cycles per frame.
//  Wrap: at count==PERIOD_CYCLES-1: if enable=1 -> count=0, new frame (no gap cycle);
//   if enable=0 -> IDLE, running=0. Deasserting enable mid-frame never cuts the pulse short.
//  IDLE->RUN: first RUN cycle has count=0, frame_start=1, pwm_out=1, active_pulse loaded from pending.
//  Reset mid-frame: pwm_out drops to 0 in the cycle after reset is sampled; pending is lost (back to RESET_PULSE).
//  active_pulse changes only at frame boundaries or reset; compares are unsigned, zero-extended to CNT_W.
// TESTING (sim with PERIOD_CYCLES=100, MIN_PULSE=6, MAX_PULSE=21, RESET_PULSE=13, CNT_W=7)
//  1 reset, enable=1, no load -> frame_start every 100 cycles; pwm_out high exactly 13 cycles from each frame_start.
//  2 load pulse_length=10 mid-frame -> current frame stays 13 high; next frame 10 high; active_pulse=10 at its frame_start.
//  3 load 2 -> frame high 6 cycles; load 500 -> high 21 cycles; load 0 -> high 6 cycles (clamp both ends).
//  4 load 15 in cycle count==99 -> the immediately following frame is 15 high (boundary bypass).
//  5 drop enable at count==5 of a 13-wide frame -> full 13 high cycles, running=0 after count 99, no further frame_start.
//  6 assert reset at count==8 with active 21 -> pwm_out=0 next cycle, active_pulse=13, IDLE until enable re-sampled.

Source files
------------

// File: rtl/servo_pwm_if.sv
// Control and status bundle between the pulse-width source and the servo PWM generator.
interface servo_pwm_if;
  logic        enable;
  logic [17:0] pulse_length;
  logic        load;
  logic        pwm_out;
  logic        frame_start;
  logic [17:0] active_pulse;
  logic        running;

  modport master (
    output enable, pulse_length, load,
    input  pwm_out, frame_start, active_pulse, running
  );

  modport slave (
    input  enable, pulse_length, load,
    output pwm_out, frame_start, active_pulse, running
  );
endinterface

// File: rtl/servo_pwm_generator.sv
// Fixed-period servo PWM: double-buffered, clamped pulse width latched at each frame boundary.
module servo_pwm_generator #(
  parameter int PERIOD_CYCLES = 2000000,
  parameter int MIN_PULSE     = 60000,
  parameter int MAX_PULSE     = 210000,
  parameter int RESET_PULSE   = 135000,
  parameter int CNT_W         = 21
) (
  input  logic        clk,
  input  logic        reset,
  servo_pwm_if.slave  bus
);

  localparam int CW = (CNT_W > 18) ? CNT_W : 18;
  localparam logic [17:0]      MIN_P   = 18'(MIN_PULSE);
  localparam logic [17:0]      MAX_P   = 18'(MAX_PULSE);
  localparam logic [17:0]      RESET_P = 18'(RESET_PULSE);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_plus;
  logic [17:0]      pending_reg;
  logic [17:0]      pending_next;
  logic [17:0]      clamped;
  logic [17:0]      active_reg;
  logic             pwm_reg;
  logic             frame_start_reg;
  logic             running_reg;
  logic             at_last;
  logic             start_frame;

  always_comb begin
    clamped = bus.pulse_length;
    if (bus.pulse_length < MIN_P)
      clamped = MIN_P;
    else if (bus.pulse_length > MAX_P)
      clamped = MAX_P;
    // A load in the cycle that closes a frame must reach the new frame.
    pending_next = bus.load ? clamped : pending_reg;
    count_plus   = count_reg + 1'b1;
    at_last      = (count_reg == LAST);
    start_frame  = bus.enable && ((state_reg == IDLE) || at_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      pending_reg     <= RESET_P;
      active_reg      <= RESET_P;
      pwm_reg         <= 1'b0;
      frame_start_reg <= 1'b0;
      running_reg     <= 1'b0;
    end else begin
      pending_reg     <= pending_next;
      frame_start_reg <= 1'b0;
      if (start_frame) begin
        state_reg       <= RUN;
        count_reg       <= '0;
        active_reg      <= pending_next;
        frame_start_reg <= 1'b1;
        pwm_reg         <= (pending_next != 18'd0);
        running_reg     <= 1'b1;
      end else if (state_reg == IDLE || at_last) begin
        // Idle, or the frame just finished with enable low: park.
        state_reg   <= IDLE;
        count_reg   <= '0;
        pwm_reg     <= 1'b0;
        running_reg <= 1'b0;
      end else begin
        count_reg <= count_plus;
        pwm_reg   <= (CW'(count_plus) < CW'(active_reg));
      end
    end
  end

  assign bus.pwm_out      = pwm_reg;
  assign bus.frame_start  = frame_start_reg;
  assign bus.active_pulse = active_reg;
  assign bus.running      = running_reg;

endmodule

// File: tb/tb_servo_pwm_generator.sv
// Directed bench for servo_pwm_generator using the reduced 100-cycle frame parameters.
module tb_servo_pwm_generator;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  servo_pwm_if bus ();

  servo_pwm_generator #(
    .PERIOD_CYCLES (100),
    .MIN_PULSE     (6),
    .MAX_PULSE     (21),
    .RESET_PULSE   (13),
    .CNT_W         (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(input string tag, input int budget);
    int n;
    n = 0;
    while (bus.frame_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.frame_start), 32'd1);
  endtask

  // Entry: count==0 cycle. Exit: the cycle after count==99.
  task automatic run_frame(input int load_at, input int load_val, input int drop_at,
                           output int high, output int contiguous, output int fs_cnt);
    bit seen_low;
    high = 0; contiguous = 1; fs_cnt = 0; seen_low = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.pwm_out === 1'b1) begin
        if (seen_low) contiguous = 0;
        else high++;
      end else begin
        seen_low = 1;
      end
      if (bus.frame_start === 1'b1) fs_cnt++;
      bus.load         = (i == load_at);
      bus.pulse_length = 18'(load_val);
      if (i == drop_at) bus.enable = 1'b0;
      tick();
    end
    bus.load = 1'b0;
  endtask

  task automatic frame_check(input string tag, input int exp_active, input int exp_high,
                             input int load_at, input int load_val, input int drop_at);
    int high, contig, fs_cnt;
    check({tag, "_active"}, 32'(bus.active_pulse), 32'(exp_active));
    run_frame(load_at, load_val, drop_at, high, contig, fs_cnt);
    $display("frame %s: active=%0d high=%0d contiguous=%0d frame_starts=%0d",
             tag, exp_active, high, contig, fs_cnt);
    check({tag, "_high"}, 32'(high), 32'(exp_high));
    check({tag, "_contig"}, 32'(contig), 32'd1);
    check({tag, "_fs"}, 32'(fs_cnt), 32'd1);
  endtask

  initial begin
    int idle_fs;
    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.load         = 1'b0;
    bus.pulse_length = '0;
    repeat (3) tick();
    check("rst_pwm", 32'(bus.pwm_out), 32'd0);
    check("rst_fs", 32'(bus.frame_start), 32'd0);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_active", 32'(bus.active_pulse), 32'd13);

    // Start: first RUN cycle follows immediately.
    reset      = 1'b0;
    bus.enable = 1'b1;
    tick();
    check("start_fs", 32'(bus.frame_start), 32'd1);
    check("start_pwm", 32'(bus.pwm_out), 32'd1);
    check("start_running", 32'(bus.running), 32'd1);

    frame_check("f1_default", 13, 13, -1, 0, -1);
    check("f2_fs_at_100", 32'(bus.frame_start), 32'd1);
    frame_check("f2_load10_mid", 13, 13, 50, 10, -1);
    frame_check("f3_uses10", 10, 10, 40, 2, -1);
    frame_check("f4_clamp_lo", 6, 6, 30, 500, -1);
    frame_check("f5_clamp_hi", 21, 21, 30, 0, -1);
    frame_check("f6_clamp_zero", 6, 6, 99, 15, -1);
    frame_check("f7_bypass15", 15, 15, 20, 13, -1);
    frame_check("f8_drop_en", 13, 13, -1, 0, 5);

    check("stop_running", 32'(bus.running), 32'd0);
    check("stop_pwm", 32'(bus.pwm_out), 32'd0);
    idle_fs = 0;
    for (int i = 0; i < 150; i++) begin
      if (bus.frame_start === 1'b1 || bus.pwm_out === 1'b1) idle_fs++;
      tick();
    end
    check("idle_no_frames", 32'(idle_fs), 32'd0);

    // Reset mid-frame with a 21-wide active pulse.
    bus.load         = 1'b1;
    bus.pulse_length = 18'd21;
    bus.enable       = 1'b1;
    tick();
    bus.load = 1'b0;
    wait_fs("f9_fs", 10);
    check("f9_active", 32'(bus.active_pulse), 32'd21);
    repeat (8) tick();
    check("f9_pwm_c8", 32'(bus.pwm_out), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_pwm", 32'(bus.pwm_out), 32'd0);
    check("mid_rst_active", 32'(bus.active_pulse), 32'd13);
    check("mid_rst_running", 32'(bus.running), 32'd0);
    reset = 1'b0;
    tick();
    check("restart_fs", 32'(bus.frame_start), 32'd1);
    frame_check("f10_after_rst", 13, 13, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
